agat_burst_cache: RTL and testbench



---
 rtl/agat_cache_pkg.sv | 11 +
 rtl/agat_cache_store.sv | 44 ++++
 rtl/agat_burst_cache.sv | 138 +++++++++++++
 tb/tb_agat_burst_cache.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/agat_cache_pkg.sv
// agat_cache_pkg: shared types and constants for the Agat-9 burst read cache.
package agat_cache_pkg;
    typedef enum logic [2:0] {IDLE, FILL_REQ, FILL, WR_REQ, WR_WAIT} state_t;
    localparam int LINE_WORDS = 8;
    localparam int OFFSET_W = 4;
    localparam logic [1:0] DQM_LO = 2'b10;
    localparam logic [1:0] DQM_HI = 2'b01;
    function automatic logic [7:0] byte_sel(input logic [15:0] d, input logic hi);
        return hi ? d[15:8] : d[7:0];
    endfunction
endpackage

// File: rtl/agat_cache_store.sv
// agat_cache_store: line data array with lane-masked writes plus tag/valid arrays.
module agat_cache_store
    import agat_cache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 11,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] idx,
    input  logic [2:0]       r_word,
    output logic [15:0]      r_data,
    output logic [TAG_W-1:0] r_tag,
    output logic             r_valid,
    input  logic             w_en,
    input  logic [2:0]       w_word,
    input  logic [1:0]       w_be,
    input  logic [15:0]      w_data,
    input  logic             set_valid,
    input  logic [TAG_W-1:0] set_tag
);
    logic [15:0]      data [LINES][LINE_WORDS];
    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;

    assign r_data  = data[idx][r_word];
    assign r_tag   = tags[idx];
    assign r_valid = valid[idx];

    always_ff @(posedge clk) begin
        if (w_en && w_be[0]) data[idx][w_word][7:0] <= w_data[7:0];
        if (w_en && w_be[1]) data[idx][w_word][15:8] <= w_data[15:8];
        if (set_valid) tags[idx] <= set_tag;
    end

    // flush outranks a completing fill so that line stays invalid
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) valid <= '0;
        else if (flush) valid <= '0;
        else if (set_valid) valid[idx] <= 1'b1;
    end
endmodule

// File: rtl/agat_burst_cache.sv
// agat_burst_cache: direct-mapped write-through read cache, one 8-word SDRAM burst per line fill.
module agat_burst_cache
    import agat_cache_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int LINES = 4,
    parameter int BURST = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              n_wait,
    input  logic              flush,
    output logic [23:0]       ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [15:0]       ram_wdata,
    output logic [1:0]        ram_dqm,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_valid,
    input  logic              ram_ack
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
    localparam logic [2:0] LAST = 3'(BURST - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, a;
    logic [2:0]        cnt, cnt_d;
    logic [7:0]        dout_d;
    logic              n_wait_d;
    logic [23:0]       ram_addr_d;
    logic [15:0]       wdata_d, r_data;
    logic [1:0]        dqm_d;
    logic [TAG_W-1:0]  r_tag;
    logic              r_valid, hit, fill;

    // IDLE decodes the live CPU address; busy states use the latched one
    assign a    = state == IDLE ? cpu_addr : addr_q;
    assign hit  = r_valid && r_tag == a[ADDR_W-1 -: TAG_W];
    assign fill = state == FILL;

    agat_cache_store #(.LINES(LINES), .TAG_W(TAG_W)) u_store (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .idx       (a[OFFSET_W +: IDX_W]),
        .r_word    (a[3:1]),
        .r_data    (r_data),
        .r_tag     (r_tag),
        .r_valid   (r_valid),
        .w_en      (fill ? ram_valid : state == IDLE && cpu_wr && hit),
        .w_word    (fill ? cnt : a[3:1]),
        .w_be      (fill ? 2'b11 : ~(a[0] ? DQM_HI : DQM_LO)),
        .w_data    (fill ? ram_rdata : {cpu_din, cpu_din}),
        .set_valid (fill && ram_valid && cnt == LAST),
        .set_tag   (a[ADDR_W-1 -: TAG_W])
    );

    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        cnt_d      = cnt;
        dout_d     = cpu_dout;
        n_wait_d   = n_wait;
        ram_addr_d = ram_addr;
        wdata_d    = ram_wdata;
        dqm_d      = ram_dqm;
        case (state)
            IDLE:
                if (cpu_wr) begin
                    state_d    = WR_REQ;
                    n_wait_d   = 1'b0;
                    ram_addr_d = 24'(a[ADDR_W-1:1]);
                    wdata_d    = {cpu_din, cpu_din};
                    dqm_d      = a[0] ? DQM_HI : DQM_LO;
                end else if (cpu_rd && hit) begin
                    dout_d = byte_sel(r_data, a[0]);
                end else if (cpu_rd) begin
                    state_d    = FILL_REQ;
                    n_wait_d   = 1'b0;
                    addr_d     = cpu_addr;
                    ram_addr_d = 24'({a[ADDR_W-1:OFFSET_W], 3'b000});
                end
            FILL_REQ: begin
                state_d = FILL;
                cnt_d   = '0;
            end
            FILL:
                if (ram_valid) begin
                    cnt_d = cnt + 3'd1;
                    if (cnt == LAST) begin
                        state_d  = IDLE;
                        n_wait_d = 1'b1;
                        dout_d   = byte_sel(a[3:1] == LAST ? ram_rdata : r_data, a[0]);
                    end
                end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT:
                if (ram_ack) begin
                    state_d  = IDLE;
                    n_wait_d = 1'b1;
                    dqm_d    = 2'b11;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            cnt       <= '0;
            cpu_dout  <= '0;
            n_wait    <= 1'b1;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_wdata <= '0;
            ram_dqm   <= 2'b11;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            cnt       <= cnt_d;
            cpu_dout  <= dout_d;
            n_wait    <= n_wait_d;
            ram_addr  <= ram_addr_d;
            ram_rd    <= state_d == FILL_REQ;
            ram_wr    <= state_d == WR_REQ;
            ram_wdata <= wdata_d;
            ram_dqm   <= dqm_d;
        end
    end
endmodule

// File: tb/tb_agat_burst_cache.sv
// tb_agat_burst_cache: scoreboard bench with a behavioural SDRAM burst model.
module tb_agat_burst_cache;
    typedef struct {
        logic        rd;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [1:0]  dqm;
    } req_t;

    logic        clk = 0, n_rst = 0;
    logic [16:0] cpu_addr = 0;
    logic        cpu_rd = 0, cpu_wr = 0, flush;
    logic [7:0]  cpu_din = 0, cpu_dout;
    logic        n_wait, ram_rd, ram_wr, ram_valid, ram_ack;
    logic [23:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [1:0]  ram_dqm;

    int n_tests = 0, n_fail = 0;
    int rd_cnt = 0, ack_cnt = 0, vcnt = 0;
    logic flush_last = 0;
    req_t reqq[$];
    logic [7:0] rdq[$];
    logic [15:0] mem [logic [23:0]];

    agat_burst_cache dut (
        .clk(clk), .n_rst(n_rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .n_wait(n_wait), .flush(flush),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
        .ram_dqm(ram_dqm), .ram_rdata(ram_rdata), .ram_valid(ram_valid), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // untouched SDRAM words: line 0x90 reads back as 0x1100..0x1107
    function automatic logic [15:0] mword(input logic [23:0] w);
        if (mem.exists(w)) return mem[w];
        return {w[10:3] ^ 8'h03, (w[10:3] ^ 8'h12) + {5'd0, w[2:0]}};
    endfunction

    function automatic logic [7:0] mbyte(input logic [16:0] a);
        logic [15:0] d = mword(24'(a[16:1]));
        return a[0] ? d[15:8] : d[7:0];
    endfunction

    task automatic check_reset();
        chk("rst_dout", cpu_dout, 0);
        chk("rst_nwait", n_wait, 1);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_dqm", ram_dqm, 2'b11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rd(input logic [16:0] a, input logic hit);
        int prev = rd_cnt;
        req_t r = '{1'b1, 24'({a[16:4], 3'b000}), 16'h0, 2'b11};
        rdq.push_back(mbyte(a));
        if (!hit) reqq.push_back(r);
        cpu_addr = a;
        cpu_rd = 1;
        tick();
        cpu_rd = 0;
        if (hit) begin
            chk("hit_nwait", n_wait, 1);
            chk("hit_dout", cpu_dout, rdq.pop_front());
            @(negedge clk);
            chk("hit_no_ram_rd", rd_cnt, prev);
        end else begin
            chk("miss_nwait", n_wait, 0);
            for (int i = 0; i < 60 && !n_wait; i++) tick();
            chk("miss_done", n_wait, 1);
            chk("miss_words", vcnt, 8);
            chk("miss_ram_rd", rd_cnt, prev + 1);
            chk("miss_dout", cpu_dout, rdq.pop_front());
        end
    endtask

    task automatic do_wr(input logic [16:0] a, input logic [7:0] d, input logic both);
        int prev = ack_cnt;
        logic [23:0] w = 24'(a[16:1]);
        logic [15:0] m = mword(w);
        reqq.push_back('{1'b0, w, {d, d}, a[0] ? 2'b01 : 2'b10});
        if (a[0]) m[15:8] = d;
        else m[7:0] = d;
        mem[w] = m;
        cpu_addr = a;
        cpu_din = d;
        cpu_wr = 1;
        cpu_rd = both;
        tick();
        cpu_wr = 0;
        cpu_rd = 0;
        chk("wr_nwait", n_wait, 0);
        for (int i = 0; i < 40 && !n_wait; i++) tick();
        chk("wr_done", n_wait, 1);
        chk("wr_ack", ack_cnt, prev + 1);
        chk("wr_dqm_idle", ram_dqm, 2'b11);
    endtask

    // SDRAM model: checks each request against the scoreboard, then serves it
    initial begin
        req_t e;
        logic [23:0] base;
        ram_valid = 0;
        ram_rdata = 0;
        ram_ack = 0;
        flush = 0;
        forever begin
            @(negedge clk);
            if (n_rst && (ram_rd || ram_wr)) begin
                chk("req_expected", reqq.size() != 0, 1);
                e = reqq.size() != 0 ? reqq.pop_front() : '{ram_rd, ram_addr, ram_wdata, ram_dqm};
                chk("req_kind", ram_rd, e.rd);
                chk("req_addr", ram_addr, e.addr);
                if (ram_rd) begin
                    rd_cnt++;
                    vcnt = 0;
                    base = e.addr;
                    @(negedge clk);
                    chk("rd_pulse", ram_rd, 0);
                    @(negedge clk);
                    for (int i = 0; i < 8 && n_rst; i++) begin
                        ram_rdata = mword(base + 24'(i));
                        ram_valid = 1;
                        flush = flush_last && i == 7;
                        @(posedge clk);
                        vcnt++;
                        @(negedge clk);
                        ram_valid = 0;
                        flush = 0;
                    end
                end else begin
                    chk("req_wdata", ram_wdata, e.wdata);
                    chk("req_dqm", ram_dqm, e.dqm);
                    @(negedge clk);
                    chk("wr_pulse", ram_wr, 0);
                    repeat (2) @(negedge clk);
                    ram_ack = 1;
                    ack_cnt++;
                    @(negedge clk);
                    ram_ack = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        repeat (3) tick();
        check_reset();
        n_rst = 1;
        tick();
        do_rd(17'h00123, 0);
        do_rd(17'h00120, 1);
        do_rd(17'h0012F, 1);
        do_wr(17'h00121, 8'hAB, 0);
        do_rd(17'h00121, 1);
        do_wr(17'h04000, 8'h5C, 0);
        do_rd(17'h04000, 0);
        do_wr(17'h04001, 8'h3E, 1);
        do_rd(17'h04001, 1);
        do_rd(17'h0001F, 0);
        flush_last = 1;
        do_rd(17'h00200, 0);
        flush_last = 0;
        do_rd(17'h00200, 0);
        prev = rd_cnt;
        reqq.push_back('{1'b1, 24'h000180, 16'h0, 2'b11});
        cpu_addr = 17'h00300;
        cpu_rd = 1;
        tick();
        cpu_rd = 0;
        for (int i = 0; i < 40 && !(rd_cnt == prev + 1 && vcnt >= 4); i++) tick();
        chk("abort_words", vcnt, 4);
        n_rst = 0;
        #1;
        check_reset();
        repeat (3) tick();
        n_rst = 1;
        tick();
        do_rd(17'h00300, 0);
        do_rd(17'h00301, 1);
        chk("queues_empty", reqq.size() + rdq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
